// File: rtl/mux_b_t_s_pkg.sv
// Shared types and helpers for the binary-to-temporal serializing mux controller.
//   state_e     : controller FSM states
//   hold_level  : select_line level that keeps the mux counter still
//   *_DEF       : default counter geometry used by the controller parameters
package mux_b_t_s_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_EMIT,
    ST_ADV,
    ST_FLUSH,
    ST_DONE
  } state_e;

  localparam int G_DEF     = 16;
  localparam int PW_DEF    = 8;
  localparam int IDX_W_DEF = $clog2(G_DEF);
  localparam int NW_W_DEF  = IDX_W_DEF + 1;

  // Rising builds advance on select_line=0, so they hold at 1; falling builds the reverse.
  function automatic logic hold_level(input bit rising_mode);
    return rising_mode ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/mux_b_t_s_ctrl_slot_timer.sv
// Loadable down-counter with a zero flag.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : value loaded; the flag rises load_val cycles after the load
//   zero       : counter currently at zero
module slot_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux_b_t_s_ctrl.sv
// Sequencing controller for the binary-to-temporal serializing mux.
// Emits a frame of num_words words, one per slot, then flushes the mux word
// counter back to 0 so the next frame starts aligned.
//   aclk, grst_n : clock, synchronous active-low reset (shared with the mux)
//   start        : frame request, accepted only in IDLE
//   num_words    : words in the frame, clamped to NUM_INPUTS
//   out_ready    : consumer can accept a new slot (looked at only in WAIT)
//   select_line  : mux select; ADV level advances the mux counter each clock
//   out_valid    : mux output holds word word_idx this cycle
//   word_idx     : mirror of the mux word counter
//   busy         : frame in progress
//   done         : one-cycle pulse at frame end
//   start_err    : one-cycle pulse after a start outside IDLE
module mux_b_t_s_ctrl
  import mux_b_t_s_pkg::*;
#(
  parameter int GAMMA_CYCLE_WIDTH = G_DEF,
  parameter int NUM_INPUTS        = GAMMA_CYCLE_WIDTH,
  parameter int PULSE_WIDTH       = PW_DEF,
  parameter int RISING_MODE       = 1
) (
  input  logic                                 aclk,
  input  logic                                 grst_n,
  input  logic                                 start,
  input  logic [$clog2(NUM_INPUTS):0]          num_words,
  input  logic                                 out_ready,
  output logic                                 select_line,
  output logic                                 out_valid,
  output logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0] word_idx,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 start_err
);

  localparam int G    = GAMMA_CYCLE_WIDTH;
  localparam int IW   = $clog2(G);
  localparam int NWW  = $clog2(NUM_INPUTS) + 1;
  localparam int TMAX = (PULSE_WIDTH > G) ? PULSE_WIDTH : G;
  localparam int TW   = $clog2(TMAX) + 1;

  localparam logic HOLD_L = hold_level(RISING_MODE != 0);
  localparam logic ADV_L  = ~HOLD_L;

  state_e           state_q, state_d;
  logic [NWW-1:0]   nw_q, nw_d;
  logic [NWW-1:0]   slots_q, slots_d;
  logic [NWW-1:0]   nw_clamp;
  logic             select_line_q, select_line_d;
  logic             out_valid_q, out_valid_d;
  logic [IW-1:0]    word_idx_q, word_idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             start_err_q, start_err_d;
  logic             timer_load;
  logic [TW-1:0]    timer_val;
  logic             timer_zero;

  always_comb begin
    state_d  = state_q;
    nw_d     = nw_q;
    slots_d  = slots_q;
    nw_clamp = (num_words > NWW'(NUM_INPUTS)) ? NWW'(NUM_INPUTS) : num_words;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          nw_d    = nw_clamp;
          slots_d = '0;
          state_d = (nw_clamp == '0) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (out_ready) state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (timer_zero) state_d = ST_ADV;
      end
      ST_ADV: begin
        slots_d = slots_q + NWW'(1);
        if (slots_d == nw_q) begin
          // A full-length frame already wrapped the counter; nothing to flush.
          state_d = (nw_q < NWW'(G)) ? ST_FLUSH : ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_FLUSH: begin
        if (timer_zero) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered, decoded from the state being entered.
    select_line_d = (state_d == ST_ADV || state_d == ST_FLUSH) ? ADV_L : HOLD_L;
    out_valid_d   = (state_d == ST_EMIT);
    busy_d        = (state_d == ST_WAIT) || (state_d == ST_EMIT) ||
                    (state_d == ST_ADV)  || (state_d == ST_FLUSH);
    done_d        = (state_d == ST_DONE);
    start_err_d   = start && (state_q != ST_IDLE);

    // Track the mux counter: it steps on every clock that sees the ADV level.
    word_idx_d = (select_line_q == ADV_L) ? word_idx_q + IW'(1) : word_idx_q;

    // Timer is (re)loaded on entry to EMIT or FLUSH; zero marks the last cycle.
    timer_load = (state_d != state_q) && (state_d == ST_EMIT || state_d == ST_FLUSH);
    timer_val  = (state_d == ST_EMIT) ? TW'(PULSE_WIDTH - 1)
                                      : TW'(G - 1) - TW'(nw_q);
  end

  always_ff @(posedge aclk) begin
    if (!grst_n) begin
      state_q       <= ST_IDLE;
      nw_q          <= '0;
      slots_q       <= '0;
      select_line_q <= HOLD_L;
      out_valid_q   <= 1'b0;
      word_idx_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      start_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      nw_q          <= nw_d;
      slots_q       <= slots_d;
      select_line_q <= select_line_d;
      out_valid_q   <= out_valid_d;
      word_idx_q    <= word_idx_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      start_err_q   <= start_err_d;
    end
  end

  slot_timer #(
    .W (TW)
  ) u_slot_timer (
    .clk      (aclk),
    .rst_n    (grst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  assign select_line = select_line_q;
  assign out_valid   = out_valid_q;
  assign word_idx    = word_idx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign start_err   = start_err_q;

endmodule

// File: tb/tb_mux_b_t_s_ctrl.sv
// Bench for mux_b_t_s_ctrl: a rising and a falling build share the same stimulus.
module tb_mux_b_t_s_ctrl;

  localparam int G     = 16;
  localparam int PW    = 8;
  localparam int IDX_W = $clog2(G);
  localparam int NW_W  = IDX_W + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             grst_n, start, out_ready;
  logic [NW_W-1:0]  num_words;
  logic             r_sel, r_vld, r_busy, r_done, r_err;
  logic [IDX_W-1:0] r_idx;
  logic             f_sel, f_vld, f_busy, f_done, f_err;
  logic [IDX_W-1:0] f_idx;

  mux_b_t_s_ctrl #(
    .GAMMA_CYCLE_WIDTH (G), .NUM_INPUTS (G), .PULSE_WIDTH (PW), .RISING_MODE (1)
  ) u_rise (
    .aclk (clk), .grst_n (grst_n), .start (start), .num_words (num_words),
    .out_ready (out_ready), .select_line (r_sel), .out_valid (r_vld),
    .word_idx (r_idx), .busy (r_busy), .done (r_done), .start_err (r_err)
  );

  mux_b_t_s_ctrl #(
    .GAMMA_CYCLE_WIDTH (G), .NUM_INPUTS (G), .PULSE_WIDTH (PW), .RISING_MODE (0)
  ) u_fall (
    .aclk (clk), .grst_n (grst_n), .start (start), .num_words (num_words),
    .out_ready (out_ready), .select_line (f_sel), .out_valid (f_vld),
    .word_idx (f_idx), .busy (f_busy), .done (f_done), .start_err (f_err)
  );

  // One record per clock: inputs to drive this cycle and outputs expected this cycle.
  // 'a' = mux counter is advancing (select_line at ADV level).
  typedef struct {
    logic             rst_n;
    logic             st;
    logic [NW_W-1:0]  nwi;
    logic             rdy;
    logic             a;
    logic             vld;
    logic [IDX_W-1:0] idx;
    logic             busy;
    logic             done;
    logic             err;
  } rec_t;

  typedef struct {
    int nw;
    int stall_slot;
    int stall_len;
    int drop_slot;
    int err_slot;
    int exp_done;   // cycles from the start cycle to the done cycle
  } scen_t;

  rec_t  sb[$];
  scen_t tbl[6];
  int    n_chk = 0;
  int    n_pass = 0;
  logic  pend_err = 1'b0;

  function automatic rec_t mk(input logic st, input int nwi, input logic rdy, input logic a,
                              input logic vld, input int idx, input logic busy, input logic done);
    rec_t r;
    r.rst_n = 1'b1; r.st = st; r.nwi = NW_W'(nwi); r.rdy = rdy; r.a = a; r.vld = vld;
    r.idx = IDX_W'(idx); r.busy = busy; r.done = done; r.err = 1'b0;
    return r;
  endfunction

  task automatic push(input rec_t r, input logic idle);
    r.err = pend_err;
    pend_err = r.st && !idle;
    sb.push_back(r);
  endtask

  task automatic gen_frame(input int nw_in, input int ss, input int sl, input int ds, input int es);
    int nw;
    int idx;
    nw  = (nw_in > G) ? G : nw_in;
    idx = 0;
    pend_err = 1'b0;
    push(mk(1'b1, nw_in, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0), 1'b1);
    for (int k = 0; k < nw; k++) begin
      for (int s = 0; s < ((k == ss) ? sl : 0); s++)
        push(mk(1'b0, 0, 1'b0, 1'b0, 1'b0, idx, 1'b1, 1'b0), 1'b0);
      push(mk(1'b0, 0, 1'b1, 1'b0, 1'b0, idx, 1'b1, 1'b0), 1'b0);
      for (int p = 0; p < PW; p++)
        push(mk((k == es) && (p == 2), 5, !((k == ds) && (p >= 2)), 1'b0, 1'b1, idx, 1'b1, 1'b0), 1'b0);
      push(mk(1'b0, 0, 1'b1, 1'b1, 1'b0, idx, 1'b1, 1'b0), 1'b0);
      idx = (idx + 1) % G;
    end
    if (nw > 0) begin
      for (int f = 0; f < G - nw; f++) begin
        push(mk(1'b0, 0, 1'b1, 1'b1, 1'b0, idx, 1'b1, 1'b0), 1'b0);
        idx = (idx + 1) % G;
      end
    end
    push(mk(1'b0, 0, 1'b1, 1'b0, 1'b0, idx, 1'b0, 1'b1), 1'b0);
    push(mk(1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0), 1'b1);
  endtask

  task automatic check(input rec_t r);
    logic [IDX_W+4:0] exp_v, got_v;
    exp_v = {~r.a, r.vld, r.idx, r.busy, r.done, r.err};
    got_v = {r_sel, r_vld, r_idx, r_busy, r_done, r_err};
    n_chk++;
    if (got_v === exp_v) n_pass++;
    else $display("FAIL rise_outputs t=%0t sel/vld/idx/busy/done/err got=%b required=%b", $time, got_v, exp_v);
    exp_v = {r.a, r.vld, r.idx, r.busy, r.done, r.err};
    got_v = {f_sel, f_vld, f_idx, f_busy, f_done, f_err};
    n_chk++;
    if (got_v === exp_v) n_pass++;
    else $display("FAIL fall_outputs t=%0t sel/vld/idx/busy/done/err got=%b required=%b", $time, got_v, exp_v);
  endtask

  // Pops one record per cycle, compares outputs, then drives that record's inputs.
  task automatic drain(output int done_off);
    rec_t r;
    int   cyc;
    cyc = -1;
    done_off = -1;
    while (sb.size() > 0) begin
      r = sb.pop_front();
      @(negedge clk);
      check(r);
      if (cyc >= 0) cyc++;
      if (r.st && cyc < 0) cyc = 0;
      if (r_done === 1'b1 && done_off < 0 && cyc >= 0) done_off = cyc;
      grst_n    = r.rst_n;
      start     = r.st;
      num_words = r.nwi;
      out_ready = r.rdy;
    end
  endtask

  initial begin
    int   d;
    rec_t t;

    tbl[0] = '{nw: 3,  stall_slot: -1, stall_len: 0, drop_slot: -1, err_slot: -1, exp_done: 44};
    tbl[1] = '{nw: 16, stall_slot: -1, stall_len: 0, drop_slot: -1, err_slot: -1, exp_done: 161};
    tbl[2] = '{nw: 3,  stall_slot: 1,  stall_len: 5, drop_slot: 1,  err_slot: -1, exp_done: 49};
    tbl[3] = '{nw: 0,  stall_slot: -1, stall_len: 0, drop_slot: -1, err_slot: -1, exp_done: 1};
    tbl[4] = '{nw: 20, stall_slot: -1, stall_len: 0, drop_slot: -1, err_slot: -1, exp_done: 161};
    tbl[5] = '{nw: 3,  stall_slot: -1, stall_len: 0, drop_slot: -1, err_slot: 0,  exp_done: 44};

    grst_n = 1'b0; start = 1'b0; out_ready = 1'b1; num_words = '0;
    repeat (2) @(posedge clk);

    push(mk(1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0), 1'b1);
    push(mk(1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0), 1'b1);
    drain(d);

    for (int i = 0; i < 6; i++) begin
      gen_frame(tbl[i].nw, tbl[i].stall_slot, tbl[i].stall_len, tbl[i].drop_slot, tbl[i].err_slot);
      drain(d);
      n_chk++;
      if (d == tbl[i].exp_done) n_pass++;
      else $display("FAIL frame_len[%0d] nw=%0d done_at=%0d required=%0d", i, tbl[i].nw, d, tbl[i].exp_done);
    end

    // Reset during slot 1 EMIT (word_idx=1): frame aborts, counter back to 0, no done.
    gen_frame(3, -1, 0, -1, -1);
    while (sb.size() > 16) void'(sb.pop_back());
    t = sb[15];
    t.rst_n = 1'b0;
    sb[15] = t;
    pend_err = 1'b0;
    for (int k = 0; k < 4; k++) push(mk(1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0), 1'b1);
    drain(d);
    n_chk++;
    if (d == -1) n_pass++;
    else $display("FAIL reset_abort_done done_at=%0d required=none", d);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
